nr_divider: RTL and testbench
=============================

NR_DIVIDER -- requirements
Module: nr_divider

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width; legal range 4..64.
REQ-002 SHALL have port clock, input, 1, sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset_n, input, 1; reset is asynchronous and active-low.
REQ-004 SHALL have port start, input, 1, request a division; sampled on rising edge.
REQ-005 SHALL have port is_signed, input, 1, 1 = two's-complement operands, 0 = unsigned; sampled with start.
REQ-006 SHALL have port dividend, input, WIDTH, numerator; sampled with start.
REQ-007 SHALL have port divisor, input, WIDTH, denominator; sampled with start.
REQ-008 SHALL have port quotient, output, WIDTH, registered result.
REQ-009 SHALL have port remainder, output, WIDTH, registered result.
REQ-010 SHALL have port busy, output, 1, high while a division is in progress.
REQ-011 SHALL have port ready, output, 1, one-cycle pulse when quotient/remainder are valid.
REQ-012 SHALL have port div_by_zero, output, 1, status of the last completed division, valid from ready onward.

Function
REQ-013 SHALL implement a state machine with states IDLE, RUN, FIX, DONE.
REQ-014 SHALL accept start only in IDLE or DONE; start in RUN or FIX SHALL be ignored with no effect.
REQ-015 On accepted start with divisor != 0 SHALL latch operands, load the iteration counter with WIDTH, and enter RUN.
REQ-016 RUN SHALL perform one non-restoring step per cycle: subtract divisor magnitude if partial remainder >= 0, else add; shift in quotient bit = NOT(sign of new partial remainder); decrement counter.
REQ-017 Partial remainder register SHALL be WIDTH+1 bits; counter width SHALL be clog2(WIDTH+1).
REQ-018 RUN SHALL exit to FIX when the counter reaches 0, after exactly WIDTH cycles.
REQ-019 FIX SHALL take one cycle: add back the divisor if the partial remainder is negative, then apply sign correction.
REQ-020 Signed mode SHALL operate on magnitudes; quotient SHALL be negated iff operand signs differ; remainder SHALL take the dividend's sign, with truncation toward zero.
REQ-021 Signed MIN / -1 SHALL yield quotient = MIN (wrap), remainder = 0, div_by_zero = 0.
REQ-022 FIX SHALL go to DONE; DONE SHALL assert ready for exactly one cycle, then go to IDLE unless start is accepted in DONE.
REQ-023 ready SHALL rise WIDTH+2 rising edges after the edge that samples start (34 for WIDTH=32).
REQ-024 On accepted start with divisor == 0 SHALL skip RUN and FIX and go directly to DONE: quotient = all ones, remainder = dividend, div_by_zero = 1; ready one edge after start.
REQ-025 busy SHALL be high in RUN and FIX and low in IDLE and DONE.
REQ-026 quotient, remainder, and div_by_zero SHALL be updated only on entry to DONE and SHALL hold until the next DONE.
REQ-027 Back-to-back: start accepted in DONE SHALL enter RUN on the next edge with no IDLE cycle.

Reset
REQ-028 reset_n low SHALL immediately force IDLE, busy = 0, ready = 0, div_by_zero = 0, quotient = 0, remainder = 0, counter = 0.
REQ-029 Reset during RUN or FIX SHALL abort the operation; no ready SHALL follow.
REQ-030 The first edge after reset_n deasserts SHALL be able to accept start.

Structure
REQ-031 The state enum and the default WIDTH SHALL reside in shared package nr_div_pkg.
REQ-032 The per-iteration add/subtract-and-shift SHALL be a combinational sub-module nr_div_step, parameterised by WIDTH; the FSM, counter, and sign fixup SHALL stay in nr_divider.

Verification
REQ-033 WIDTH=32, unsigned 100/7 -> quotient 14, remainder 2, div_by_zero 0, ready 34 edges after start, busy high 33 cycles.
REQ-034 Signed -100/7 -> quotient 0xFFFFFFF2 (-14), remainder 0xFFFFFFFE (-2); signed 100/-7 -> quotient -14, remainder 2.
REQ-035 Unsigned 5/0 -> ready 1 edge after start, quotient 0xFFFFFFFF, remainder 5, div_by_zero 1, busy never high.
REQ-036 Signed 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000, remainder 0; unsigned same operands -> quotient 0, remainder 0x80000000.
REQ-037 Second start during RUN with different operands -> ignored, first result returned; start in DONE cycle -> next ready exactly 34 edges later.
REQ-038 reset_n pulsed low at cycle 10 of RUN -> outputs zero immediately, no ready pulse, new start afterwards completes normally.

Source files
------------

// File: rtl/nr_div_pkg.sv
// Shared definitions for the non-restoring divider: FSM state encoding and default width.
package nr_div_pkg;

  localparam int unsigned DefaultWidth = 32;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StFix,
    StDone
  } nr_div_state_e;

endpackage

// File: rtl/nr_div_step.sv
// One non-restoring iteration: shift the {remainder, quotient} pair left, then add or
// subtract the divisor magnitude depending on the sign of the incoming partial remainder.
module nr_div_step
  import nr_div_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic [WIDTH:0]   part_rem,
  input  logic [WIDTH-1:0] part_quo,
  input  logic [WIDTH-1:0] divisor_mag,
  output logic [WIDTH:0]   next_rem,
  output logic [WIDTH-1:0] next_quo
);

  logic [WIDTH:0] shifted;

  always_comb begin
    // Arithmetic is modulo 2^(WIDTH+1); the true result always lies in [-D, D), so it fits.
    shifted = {part_rem[WIDTH-1:0], part_quo[WIDTH-1]};
    if (!part_rem[WIDTH]) begin
      next_rem = shifted - {1'b0, divisor_mag};
    end else begin
      next_rem = shifted + {1'b0, divisor_mag};
    end
    next_quo = {part_quo[WIDTH-2:0], ~next_rem[WIDTH]};
  end

endmodule

// File: rtl/nr_divider.sv
// Multi-cycle signed/unsigned non-restoring divider: one quotient bit per clock,
// followed by a single remainder-restore and sign-fixup cycle.
module nr_divider
  import nr_div_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             ready,
  output logic             div_by_zero
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  nr_div_state_e    state;
  logic [CntW-1:0]  cnt;
  logic [WIDTH:0]   prem;
  logic [WIDTH-1:0] quo_acc;
  logic [WIDTH-1:0] dvsr;
  logic             neg_q;
  logic             neg_r;

  logic [WIDTH:0]   step_rem;
  logic [WIDTH-1:0] step_quo;
  logic [WIDTH-1:0] dvd_mag;
  logic [WIDTH-1:0] dvs_mag;
  logic [WIDTH-1:0] rem_mag;
  logic [WIDTH-1:0] quo_final;
  logic [WIDTH-1:0] rem_final;
  logic             accept;

  nr_div_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .part_rem   (prem),
    .part_quo   (quo_acc),
    .divisor_mag(dvsr),
    .next_rem   (step_rem),
    .next_quo   (step_quo)
  );

  always_comb begin
    accept  = start && (state == StIdle || state == StDone);
    dvd_mag = (is_signed && dividend[WIDTH-1]) ? -dividend : dividend;
    dvs_mag = (is_signed && divisor[WIDTH-1]) ? -divisor : divisor;
    // Remainder is in [-D, D) after the last step, so one conditional add-back restores it.
    rem_mag   = prem[WIDTH] ? (prem[WIDTH-1:0] + dvsr) : prem[WIDTH-1:0];
    quo_final = neg_q ? -quo_acc : quo_acc;
    rem_final = neg_r ? -rem_mag : rem_mag;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= StIdle;
      cnt         <= '0;
      prem        <= '0;
      quo_acc     <= '0;
      dvsr        <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      busy        <= 1'b0;
      ready       <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      ready <= (state == StDone);
      unique case (state)
        StIdle, StDone: begin
          if (accept) begin
            if (divisor == '0) begin
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
              state       <= StDone;
            end else begin
              dvsr    <= dvs_mag;
              quo_acc <= dvd_mag;
              prem    <= '0;
              neg_q   <= is_signed && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
              neg_r   <= is_signed && dividend[WIDTH-1];
              cnt     <= CntW'(WIDTH);
              busy    <= 1'b1;
              state   <= StRun;
            end
          end else begin
            state <= StIdle;
          end
        end
        StRun: begin
          prem    <= step_rem;
          quo_acc <= step_quo;
          cnt     <= cnt - CntW'(1);
          if (cnt == CntW'(1)) begin
            state <= StFix;
          end
        end
        StFix: begin
          quotient    <= quo_final;
          remainder   <= rem_final;
          div_by_zero <= 1'b0;
          busy        <= 1'b0;
          state       <= StDone;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_nr_divider.sv
// Directed-vector bench for nr_divider at WIDTH=32 with hand-computed expected results.
module tb_nr_divider;

  localparam int unsigned W = 32;

  logic         clock;
  logic         reset_n;
  logic         start;
  logic         is_signed;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         busy;
  logic         ready;
  logic         div_by_zero;

  int checks;
  int failures;
  int lat;
  int busy_cyc;
  int seen_ready;

  nr_divider #(
    .WIDTH(W)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .start      (start),
    .is_signed  (is_signed),
    .dividend   (dividend),
    .divisor    (divisor),
    .quotient   (quotient),
    .remainder  (remainder),
    .busy       (busy),
    .ready      (ready),
    .div_by_zero(div_by_zero)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drive start for exactly one rising edge; returns 1 time unit after that edge.
  task automatic issue(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clock);
    start     = 1'b1;
    is_signed = sgn;
    dividend  = a;
    divisor   = b;
    @(posedge clock);
    #1;
    start = 1'b0;
  endtask

  // Counts edges from the sampling edge until ready, and cycles with busy high.
  task automatic wait_ready(output int edges, output int bcyc);
    edges = 0;
    bcyc  = busy ? 1 : 0;
    while (edges < 100) begin
      @(posedge clock);
      #1;
      edges++;
      if (ready) break;
      if (busy) bcyc++;
    end
    if (edges >= 100) check_val("ready_timeout", 64'(ready), 64'd1);
  endtask

  task automatic run_div(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b);
    issue(sgn, a, b);
    wait_ready(lat, busy_cyc);
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    reset_n   = 1'b0;
    start     = 1'b0;
    is_signed = 1'b0;
    dividend  = '0;
    divisor   = '0;
    repeat (2) @(posedge clock);
    #1;
    check_val("rst_quotient", 64'(quotient), 64'd0);
    check_val("rst_remainder", 64'(remainder), 64'd0);
    check_val("rst_busy", 64'(busy), 64'd0);
    check_val("rst_ready", 64'(ready), 64'd0);
    check_val("rst_dbz", 64'(div_by_zero), 64'd0);
    @(negedge clock);
    reset_n = 1'b1;

    run_div(1'b0, 32'd100, 32'd7);
    check_val("u100_7_q", 64'(quotient), 64'd14);
    check_val("u100_7_r", 64'(remainder), 64'd2);
    check_val("u100_7_dbz", 64'(div_by_zero), 64'd0);
    check_val("u100_7_lat", 64'(lat), 64'd34);
    check_val("u100_7_busy", 64'(busy_cyc), 64'd33);
    @(posedge clock);
    #1;
    check_val("ready_one_cycle", 64'(ready), 64'd0);

    run_div(1'b1, 32'hFFFF_FF9C, 32'd7);
    check_val("sn100_7_q", 64'(quotient), 64'hFFFF_FFF2);
    check_val("sn100_7_r", 64'(remainder), 64'hFFFF_FFFE);

    run_div(1'b1, 32'd100, 32'hFFFF_FFF9);
    check_val("s100_n7_q", 64'(quotient), 64'hFFFF_FFF2);
    check_val("s100_n7_r", 64'(remainder), 64'd2);

    run_div(1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFE);
    check_val("sn7_n2_q", 64'(quotient), 64'd3);
    check_val("sn7_n2_r", 64'(remainder), 64'hFFFF_FFFF);

    run_div(1'b0, 32'd5, 32'd0);
    check_val("dz_lat", 64'(lat), 64'd1);
    check_val("dz_q", 64'(quotient), 64'hFFFF_FFFF);
    check_val("dz_r", 64'(remainder), 64'd5);
    check_val("dz_flag", 64'(div_by_zero), 64'd1);
    check_val("dz_busy", 64'(busy_cyc), 64'd0);

    run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    check_val("smin_q", 64'(quotient), 64'h8000_0000);
    check_val("smin_r", 64'(remainder), 64'd0);
    check_val("smin_dbz", 64'(div_by_zero), 64'd0);

    run_div(1'b0, 32'h8000_0000, 32'hFFFF_FFFF);
    check_val("umin_q", 64'(quotient), 64'd0);
    check_val("umin_r", 64'(remainder), 64'h8000_0000);

    run_div(1'b0, 32'hFFFF_FFFF, 32'd1);
    check_val("umax_1_q", 64'(quotient), 64'hFFFF_FFFF);
    check_val("umax_1_r", 64'(remainder), 64'd0);

    // Start during RUN must be ignored: first operation finishes on its own schedule.
    issue(1'b0, 32'd1000, 32'd10);
    repeat (5) @(posedge clock);
    issue(1'b0, 32'd9, 32'd3);
    wait_ready(lat, busy_cyc);
    check_val("ign_lat", 64'(lat), 64'd28);
    check_val("ign_q", 64'(quotient), 64'd100);
    check_val("ign_r", 64'(remainder), 64'd0);

    // Back-to-back: assert start in the DONE cycle (first cycle busy is low).
    issue(1'b0, 32'd200, 32'd10);
    lat = 0;
    while (busy && lat < 100) begin
      @(posedge clock);
      #1;
      lat++;
    end
    check_val("b2b_first_lat", 64'(lat), 64'd33);
    start     = 1'b1;
    is_signed = 1'b0;
    dividend  = 32'd300;
    divisor   = 32'd7;
    @(posedge clock);
    #1;
    start = 1'b0;
    check_val("b2b_first_ready", 64'(ready), 64'd1);
    check_val("b2b_first_q", 64'(quotient), 64'd20);
    check_val("b2b_no_idle", 64'(busy), 64'd1);
    wait_ready(lat, busy_cyc);
    check_val("b2b_lat", 64'(lat), 64'd34);
    check_val("b2b_q", 64'(quotient), 64'd42);
    check_val("b2b_r", 64'(remainder), 64'd6);

    // Reset in the middle of RUN aborts the operation.
    issue(1'b0, 32'd100, 32'd7);
    repeat (10) @(posedge clock);
    #1;
    reset_n = 1'b0;
    #1;
    check_val("abort_q", 64'(quotient), 64'd0);
    check_val("abort_r", 64'(remainder), 64'd0);
    check_val("abort_busy", 64'(busy), 64'd0);
    #3;
    reset_n = 1'b1;
    seen_ready = 0;
    repeat (40) begin
      @(posedge clock);
      #1;
      if (ready) seen_ready = 1;
    end
    check_val("abort_no_ready", 64'(seen_ready), 64'd0);
    run_div(1'b0, 32'd100, 32'd7);
    check_val("post_abort_lat", 64'(lat), 64'd34);
    check_val("post_abort_q", 64'(quotient), 64'd14);
    check_val("post_abort_r", 64'(remainder), 64'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
